// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock/tick generator: per-channel divisor, square or
// pulse output, count enable, glitch-free divisor updates and a global phase restart.
module clock_div_prog #(
    parameter int          NCH         = 2,
    parameter int          CW          = 32,
    parameter int unsigned DEFAULT_DIV = 20000,
    localparam int         CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clkin,
    input  logic           reset,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic           cfg_mode,
    input  logic [NCH-1:0] en,
    input  logic           sync_all,
    output logic [NCH-1:0] clkout,
    output logic [NCH-1:0] tick
);

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_t;

    logic [CW-1:0] w_cfg_div;
    mode_t         w_cfg_mode;

    // A divisor of 0 is meaningless; run it as divide-by-1.
    assign w_cfg_div  = (cfg_div == '0) ? CW'(1) : cfg_div;
    assign w_cfg_mode = mode_t'(cfg_mode);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] r_div;
        logic [CW-1:0] r_pdiv;
        mode_t         r_mode;
        mode_t         r_pmode;
        logic          r_pend;
        logic          r_clk;
        logic          r_tick;

        logic [CW-1:0] w_cnt_nxt;
        logic [CW-1:0] w_div_nxt;
        logic [CW-1:0] w_pdiv_nxt;
        mode_t         w_mode_nxt;
        mode_t         w_pmode_nxt;
        logic          w_pend_nxt;
        logic          w_clk_nxt;
        logic          w_tick_nxt;

        logic          w_wr;
        logic          w_term;
        logic [CW-1:0] w_app_div;
        mode_t         w_app_mode;

        // Indices >= NCH never match any channel, so such writes are dropped.
        assign w_wr   = cfg_we && (cfg_ch == CHW'(i));
        assign w_term = (r_cnt == r_div - CW'(1));

        // Config adopted at a restart point: a same-cycle write beats a pending one.
        always_comb begin
            w_app_div  = r_div;
            w_app_mode = r_mode;
            if (w_wr) begin
                w_app_div  = w_cfg_div;
                w_app_mode = w_cfg_mode;
            end else if (r_pend) begin
                w_app_div  = r_pdiv;
                w_app_mode = r_pmode;
            end
        end

        always_comb begin
            w_cnt_nxt   = r_cnt;
            w_div_nxt   = r_div;
            w_mode_nxt  = r_mode;
            w_pdiv_nxt  = r_pdiv;
            w_pmode_nxt = r_pmode;
            w_pend_nxt  = r_pend;
            w_clk_nxt   = r_clk;
            w_tick_nxt  = 1'b0;

            if (sync_all) begin
                w_cnt_nxt  = '0;
                w_div_nxt  = w_app_div;
                w_mode_nxt = w_app_mode;
                w_pend_nxt = 1'b0;
                w_clk_nxt  = 1'b0;
            end else if (!en[i]) begin
                if (w_wr) begin
                    w_cnt_nxt  = '0;
                    w_div_nxt  = w_cfg_div;
                    w_mode_nxt = w_cfg_mode;
                    w_pend_nxt = 1'b0;
                    w_clk_nxt  = 1'b0;
                end
            end else if (w_term) begin
                w_cnt_nxt  = '0;
                w_tick_nxt = 1'b1;
                w_div_nxt  = w_app_div;
                w_mode_nxt = w_app_mode;
                w_pend_nxt = 1'b0;
                if (w_app_mode != r_mode) begin
                    w_clk_nxt = 1'b0;
                end else if (r_mode == MODE_PULSE) begin
                    w_clk_nxt = 1'b1;
                end else begin
                    w_clk_nxt = ~r_clk;
                end
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_mode == MODE_PULSE) begin
                    w_clk_nxt = 1'b0;
                end
                // Running channel: hold the write until the current period ends.
                if (w_wr) begin
                    w_pend_nxt  = 1'b1;
                    w_pdiv_nxt  = w_cfg_div;
                    w_pmode_nxt = w_cfg_mode;
                end
            end
        end

        always_ff @(posedge clkin) begin
            if (reset) begin
                r_cnt   <= '0;
                r_div   <= CW'(DEFAULT_DIV);
                r_mode  <= MODE_SQUARE;
                r_pdiv  <= CW'(DEFAULT_DIV);
                r_pmode <= MODE_SQUARE;
                r_pend  <= 1'b0;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_div   <= w_div_nxt;
                r_mode  <= w_mode_nxt;
                r_pdiv  <= w_pdiv_nxt;
                r_pmode <= w_pmode_nxt;
                r_pend  <= w_pend_nxt;
                r_clk   <= w_clk_nxt;
                r_tick  <= w_tick_nxt;
            end
        end

        assign clkout[i] = r_clk;
        assign tick[i]   = r_tick;
    end

endmodule

// File: tb/tb_clock_div_prog.sv
// Scoreboarded bench for clock_div_prog: a behavioural model queues the expected
// outputs for every edge, plus directed checks on the key timing scenarios.
module tb_clock_div_prog;
    localparam int NCH = 2;
    localparam int CW  = 32;
    localparam int DEF = 4;

    logic           clkin = 1'b0;
    logic           reset;
    logic           cfg_we;
    logic [0:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_mode;
    logic [NCH-1:0] en;
    logic           sync_all;
    logic [NCH-1:0] clkout;
    logic [NCH-1:0] tick;

    clock_div_prog #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(DEF)) dut (
        .clkin(clkin), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .en(en), .sync_all(sync_all),
        .clkout(clkout), .tick(tick)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;
    logic [2*NCH-1:0] exp_q[$];

    int unsigned m_c[NCH];
    int unsigned m_div[NCH];
    int unsigned m_pdiv[NCH];
    bit          m_mode[NCH];
    bit          m_pmode[NCH];
    bit          m_pend[NCH];
    bit          m_clk[NCH];
    bit          m_tick[NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Next-state of the reference model for the upcoming posedge.
    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            bit          wr = cfg_we && (int'(cfg_ch) == i);
            int unsigned nd = (cfg_div == 0) ? 1 : int'(cfg_div);
            if (reset) begin
                m_c[i] = 0; m_div[i] = DEF; m_mode[i] = 0; m_pdiv[i] = DEF;
                m_pmode[i] = 0; m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
            end else if (sync_all) begin
                if (wr) begin
                    m_div[i] = nd; m_mode[i] = cfg_mode;
                end else if (m_pend[i]) begin
                    m_div[i] = m_pdiv[i]; m_mode[i] = m_pmode[i];
                end
                m_pend[i] = 0; m_c[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
            end else if (!en[i]) begin
                m_tick[i] = 0;
                if (wr) begin
                    m_div[i] = nd; m_mode[i] = cfg_mode; m_c[i] = 0; m_clk[i] = 0; m_pend[i] = 0;
                end
            end else if (m_c[i] + 1 == m_div[i]) begin
                bit om = m_mode[i];
                if (wr) begin
                    m_div[i] = nd; m_mode[i] = cfg_mode;
                end else if (m_pend[i]) begin
                    m_div[i] = m_pdiv[i]; m_mode[i] = m_pmode[i];
                end
                m_pend[i] = 0; m_c[i] = 0; m_tick[i] = 1;
                if (m_mode[i] != om) m_clk[i] = 0;
                else if (om) m_clk[i] = 1;
                else m_clk[i] = !m_clk[i];
            end else begin
                m_c[i]++;
                m_tick[i] = 0;
                if (m_mode[i]) m_clk[i] = 0;
                if (wr) begin
                    m_pend[i] = 1; m_pdiv[i] = nd; m_pmode[i] = cfg_mode;
                end
            end
        end
    endtask

    task automatic cyc();
        logic [2*NCH-1:0] e;
        model_edge();
        for (int i = 0; i < NCH; i++) begin
            e[NCH+i] = m_clk[i];
            e[i]     = m_tick[i];
        end
        exp_q.push_back(e);
        @(posedge clkin);
        #1;
        e = exp_q.pop_front();
        check("sb_clk_tick", 32'({clkout, tick}), 32'(e));
    endtask

    task automatic do_reset();
        reset = 1'b1; cfg_we = 1'b0; sync_all = 1'b0; en = '0;
        cyc();
        cyc();
        check("rst_clkout", 32'(clkout), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        reset = 1'b0;
    endtask

    task automatic write(input int ch, input int unsigned d, input bit m);
        cfg_we = 1'b1; cfg_ch = 1'(ch); cfg_div = CW'(d); cfg_mode = m;
    endtask

    initial begin
        int f0, f1, fb;
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        en = '0; sync_all = 1'b0;

        // Default divide-by-4, square wave
        do_reset();
        en = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check("s1_tick0", 32'(tick[0]), 32'(k % 4 == 0));
            check("s1_clk0", 32'(clkout[0]), 32'((k / 4) % 2));
        end

        // Pending pulse-mode write on ch1 applied at its next terminal
        do_reset();
        en = 2'b11;
        cyc();
        write(1, 3, 1'b1);
        cyc();
        cfg_we = 1'b0;
        cyc();
        cyc();
        check("s2_sw_tick1", 32'(tick[1]), 32'd1);
        check("s2_sw_clk1", 32'(clkout[1]), 32'd0);
        for (int k = 5; k <= 13; k++) begin
            cyc();
            check("s2_tick1", 32'(tick[1]), 32'(k == 7 || k == 10 || k == 13));
            check("s2_clk1", 32'(clkout[1]), 32'(k == 7 || k == 10 || k == 13));
        end

        // Enable drop holds count and output
        do_reset();
        en = 2'b11;
        cyc();
        cyc();
        en = 2'b10;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("s3_hold_tick0", 32'(tick[0]), 32'd0);
            check("s3_hold_clk0", 32'(clkout[0]), 32'd0);
        end
        en = 2'b11;
        f0 = 0;
        for (int k = 1; k <= 10 && f0 == 0; k++) begin
            cyc();
            if (tick[0]) f0 = k;
        end
        check("s3_resume_lat", 32'(f0), 32'd2);

        // Divisor 0 written while disabled behaves as 1
        en = 2'b10;
        write(0, 0, 1'b0);
        cyc();
        cfg_we = 1'b0;
        check("s4_clr_clk0", 32'(clkout[0]), 32'd0);
        en = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check("s4_tick0", 32'(tick[0]), 32'd1);
            check("s4_clk0", 32'(clkout[0]), 32'(k % 2));
        end

        // Phase-aligned restart with divisors 3 and 5
        en = 2'b00;
        write(0, 3, 1'b0);
        cyc();
        write(1, 5, 1'b0);
        cyc();
        cfg_we = 1'b0;
        en = 2'b11;
        for (int k = 0; k < 7; k++) cyc();
        sync_all = 1'b1;
        cyc();
        sync_all = 1'b0;
        check("s5_sync_clk", 32'(clkout), 32'd0);
        check("s5_sync_tick", 32'(tick), 32'd0);
        f0 = 0; f1 = 0; fb = 0;
        for (int k = 1; k <= 20 && fb == 0; k++) begin
            cyc();
            if (tick[0] && f0 == 0) f0 = k;
            if (tick[1] && f1 == 0) f1 = k;
            if (tick == 2'b11) fb = k;
        end
        check("s5_first_t0", 32'(f0), 32'd3);
        check("s5_first_t1", 32'(f1), 32'd5);
        check("s5_coincide", 32'(fb), 32'd15);

        // Reset discards a pending write and restores the default divisor
        write(0, 7, 1'b0);
        cyc();
        cfg_we = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        check("s6_rst_clk", 32'(clkout), 32'd0);
        check("s6_rst_tick", 32'(tick), 32'd0);
        reset = 1'b0;
        f0 = 0; f1 = 0; fb = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (tick[0] && f0 == 0) f0 = k;
            else if (tick[0] && fb == 0) fb = k;
            if (tick[1] && f1 == 0) f1 = k;
        end
        check("s6_first_t0", 32'(f0), 32'd4);
        check("s6_second_t0", 32'(fb), 32'd8);
        check("s6_first_t1", 32'(f1), 32'd4);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            reset    = ($urandom_range(0, 99) == 0);
            sync_all = ($urandom_range(0, 29) == 0);
            cfg_we   = ($urandom_range(0, 4) == 0);
            cfg_ch   = 1'($urandom_range(0, 1));
            cfg_div  = CW'($urandom_range(0, 6));
            cfg_mode = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/clock_div_prog.md
Name: clock_div_prog

Overview:
- Parametrised multi-channel clock/tick generator.
- Next generation of the fixed-ratio single-output divider used to slow the CPU clock.
- Each channel has a runtime-programmable divisor, square-wave or single-pulse mode, per-channel enable, and a one-cycle tick strobe.
- Divisor changes are glitch-free, and a global phase-align restart is provided.
- Sits between the board clock and the CPU / program counter / peripheral timing inputs.

Parameters:
NCH, 2, number of independent output channels (>=2)
CW, 32, divisor and counter width in bits
DEFAULT_DIV, 20000, divisor loaded into every channel at reset (must be >=1 and <2^CW)

Ports:
clkin  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
cfg_we  input  1  configuration write strobe, sampled on posedge
cfg_ch  input  $clog2(NCH)  channel targeted by cfg_we; out-of-range index ignored
cfg_div  input  CW  new divisor; 0 treated as 1
cfg_mode  input  1  new mode: 0 = square wave, 1 = pulse
en  input  NCH  per-channel count enable
sync_all  input  1  restart all channels phase-aligned
clkout  output  NCH  divided outputs, registered
tick  output  NCH  one-cycle strobe per terminal count, registered

Behaviour:
- Reset (synchronous, active-high), applied at posedge while reset=1:
  - all counters = 0; active div = DEFAULT_DIV; active mode = square.
  - pending div = DEFAULT_DIV, pending flags cleared.
  - clkout = 0; tick = 0.
- Reset mid-count discards pending configuration.
- Per-channel state:
  - counter c[CW-1:0]; active div/mode.
  - pending div/mode plus pending flag.
- Terminal condition per channel: en[i]=1 and c == div-1.
- Counting, each posedge with en[i]=1:
  - not terminal: c <= c+1.
  - terminal: c <= 0; tick[i] <= 1.
  - square mode: clkout[i] toggles at terminal. Half-period = div enabled cycles; period = 2*div.
  - pulse mode: clkout[i] <= 1 for the cycle after terminal, else 0. Period = div cycles.
- tick[i] is 0 on every non-terminal cycle.
- en[i]=0: c and clkout hold; tick[i] = 0. Counting resumes from the held count when en returns.
- Latency: after reset release with en=1 and div=N, the first toggle/tick appears after N posedges (registered on the N-th edge).
- Config write (cfg_we=1, valid cfg_ch=k):
  - If en[k]=0: applied immediately: active div/mode updated, c <= 0, clkout[k] <= 0.
  - If en[k]=1: stored as pending and applied at the next terminal count of channel k, so the current period completes untouched (glitch-free).
  - Write in the same cycle as channel k's terminal: the written value is applied at that terminal.
  - Second write before the pending value is applied: overwrites the pending value (last write wins).
- Mode change applied at a terminal forces clkout[k] <= 0 on that edge; tick still pulses.
- div = 1:
  - square: clkout = clkin/2.
  - pulse: clkout held 1 and tick asserted every enabled cycle.
- sync_all=1:
  - all c <= 0; all clkout <= 0; all tick <= 0.
  - pending configs applied to all channels.
  - A cfg write in the same cycle is applied too.
- Priority: reset > sync_all > config write > counting.
- Counter never exceeds div-1. Width arithmetic is CW-bit unsigned; no wrap beyond div-1 is possible.

Test Plan:
- Reset, DEFAULT_DIV=4, NCH=2, en=2'b11 -> clkout[0] rises on posedge 4 after reset release and toggles every 4 cycles (period 8); tick high 1 cycle at cycles 4, 8, 12.
- Ch1 cfg_div=3, cfg_mode=1 while en[1]=1 mid-period (c=1 of 4) -> old period finishes at cycle 4; thereafter clkout[1]=tick[1], high 1 of every 3 cycles; clkout[1] forced 0 at the switch.
- en[0] dropped for 5 cycles at c=2 -> clkout[0], c hold and no tick; after re-enable, terminal arrives 2 cycles later (c resumes 2->3).
- cfg_div=0 to ch0 with en[0]=0 -> treated as 1; after enable, clkout[0] toggles every cycle, tick[0] constantly 1.
- Channels with div 3 and 5 running; sync_all pulsed -> both clkout=0, c=0 next cycle; first ticks at +3 and +5 cycles, first coincident tick at +15.
- reset asserted mid-period with a pending write -> all outputs 0 next edge, pending discarded, div returns to DEFAULT_DIV.
